// File: rtl/uart_pkg.sv
// Shared UART definitions: rx state encoding, oversample rate and sample points.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int         OS_RATE = 16;
  localparam logic [3:0] SAMP_A  = 4'd7;
  localparam logic [3:0] SAMP_B  = 4'd8;
  localparam logic [3:0] SAMP_C  = 4'd9;
  localparam logic [3:0] OS_LAST = 4'(OS_RATE - 1);

  // 2-of-3 majority used for the bit decision
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_os16_if.sv
// Byte-side interface of the UART receiver: data handshake plus status pulses.
interface uart_rx_os16_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun, busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun, busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_sync.sv
// 2-FF synchronizer for an asynchronous line that idles high, plus a
// registered falling-edge strobe. All flops reset to the idle level so a
// reset release never fabricates an edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_fall
);
  logic r_s1, r_s2, r_s2_q, r_fall;

  // synchronize, then register the high->low transition of the synced value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_s2_q <= 1'b1;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_s2_q <= r_s2;
      r_fall <= r_s2_q & ~r_s2;
    end
  end

  assign o_sync = r_s2;
  assign o_fall = r_fall;
endmodule

// File: rtl/uart_rx_os16.sv
// UART receiver on a 16x oversample tick derived from the divider output.
// Start-bit glitch rejection, 3-sample majority per bit, stop-bit framing
// check, valid/ready byte output with overrun detection.
// Optional parity check compiled in with `define UART_RX_PARITY_EN.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_div_clk,
  input  logic           i_rxd,
  uart_rx_os16_if.master rx_if
);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic                 r_div_q;
  logic                 w_tick;
  logic                 w_rxd_s;
  logic                 w_start_edge;
  rx_state_e            r_state, w_state_nxt;
  logic [3:0]           r_os_cnt;
  logic [2:0]           r_bit_cnt;
  logic                 r_samp_a, r_samp_b;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid, r_frame_err, r_parity_err, r_overrun;
  logic                 w_bit, w_at_c, w_at_last, w_stop_dec, w_par_bad, w_deliver;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(i_rxd),
    .o_sync (w_rxd_s),
    .o_fall (w_start_edge)
  );

  // divider output is treated as data: one register for its rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_div_q <= 1'b0;
    else        r_div_q <= i_div_clk;
  end

  assign w_tick    = i_div_clk & ~r_div_q;
  assign w_at_c    = w_tick && (r_os_cnt == SAMP_C);
  assign w_at_last = w_tick && (r_os_cnt == OS_LAST);
  // third sample is the live synced value at the decision tick
  assign w_bit     = maj3(r_samp_a, r_samp_b, w_rxd_s);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state logic; STOP leaves at the mid-bit decision so back-to-back
  // frames with a short stop bit are still caught
  always_comb begin
    w_state_nxt = r_state;
    w_stop_dec  = 1'b0;
    case (r_state)
      IDLE:  if (w_start_edge) w_state_nxt = START;
      START: begin
        if (w_at_c && w_bit) w_state_nxt = IDLE;
        else if (w_at_last)  w_state_nxt = DATA;
      end
      DATA: begin
        if (w_at_last && (r_bit_cnt == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (w_at_last) w_state_nxt = STOP;
`endif
      STOP: begin
        if (w_at_c) begin
          w_state_nxt = IDLE;
          w_stop_dec  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // oversample counter, sample capture, bit counter and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_samp_a  <= 1'b1;
      r_samp_b  <= 1'b1;
      r_shreg   <= '0;
    end else begin
      if (r_state == IDLE) r_os_cnt <= '0;
      else if (w_tick)     r_os_cnt <= r_os_cnt + 4'd1;

      if (w_tick && (r_os_cnt == SAMP_A)) r_samp_a <= w_rxd_s;
      if (w_tick && (r_os_cnt == SAMP_B)) r_samp_b <= w_rxd_s;

      if ((r_state == START) && w_at_last)     r_bit_cnt <= '0;
      else if ((r_state == DATA) && w_at_last) r_bit_cnt <= r_bit_cnt + 3'd1;

      // LSB arrives first, so shifting in at the MSB leaves the byte aligned
      if ((r_state == DATA) && w_at_c) r_shreg <= {w_bit, r_shreg[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic r_par_bad;

  // parity verdict latched at the parity bit, consumed at the stop decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_par_bad <= 1'b0;
    else if ((r_state == PARITY) && w_at_c)
      r_par_bad <= ((^r_shreg) ^ w_bit) != PAR_ODD;
  end

  assign w_par_bad = r_par_bad;
`else
  assign w_par_bad = 1'b0;
`endif

  assign w_deliver = w_stop_dec && w_bit && !w_par_bad;

  // byte hand-off and one-cycle status pulses; an unconsumed byte is kept
  // and the newer one dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err  <= w_stop_dec && !w_bit;
      r_parity_err <= w_stop_dec && w_bit && w_par_bad;
      r_overrun    <= w_deliver && r_rx_valid && !rx_if.rx_ready;
      if (w_deliver && (!r_rx_valid || rx_if.rx_ready)) begin
        r_rx_data  <= r_shreg;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_if.rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data    = r_rx_data;
  assign rx_if.rx_valid   = r_rx_valid;
  assign rx_if.frame_err  = r_frame_err;
  assign rx_if.parity_err = r_parity_err;
  assign rx_if.overrun    = r_overrun;
  assign rx_if.busy       = (r_state != IDLE);
endmodule
